// File: rtl/mem_access_unit.sv
// Memory-stage load/store engine: alignment/mode checks, word-wide req/ack bus
// with byte enables, load extraction with sign/zero extension, and a bus timeout.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid,
  input  logic        load,
  input  logic        store,
  input  logic [2:0]  memory_mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [1:0]  fault_cause,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  logic [1:0]  state;
  logic [2:0]  mode_r;
  logic [1:0]  lane_r;
  logic        fault_r;
  logic [1:0]  cause_r;
  logic [15:0] tmo_cnt;

  logic        start;
  logic        mode_illegal;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wd_n;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // Handshakes: the stage offers an op with valid and is accepted on the edge
  // where start is high (stall doubles as "not ready for the next op"); on the
  // bus, mem_req and its attributes stay stable until the edge that sees mem_ack.
  assign start       = (state == S_IDLE) & valid & (load | store);
  assign stall       = start | (state == S_REQ);
  assign mem_req     = (state == S_REQ);
  assign done        = (state == S_DONE);
  assign fault       = done & fault_r;
  assign fault_cause = done ? cause_r : CAUSE_NONE;
  assign dbg_state   = state;

  always_comb begin
    mode_illegal = 1'b0;
    misaligned   = 1'b0;
    be_n         = 4'b0000;
    wd_n         = wdata;
    case (memory_mode)
      3'b000, 3'b100: begin
        be_n = 4'b0001 << addr[1:0];
        wd_n = {4{wdata[7:0]}};
      end
      3'b001, 3'b101: begin
        be_n       = addr[1] ? 4'b1100 : 4'b0011;
        wd_n       = {2{wdata[15:0]}};
        misaligned = addr[0];
      end
      3'b011: begin
        be_n       = 4'b1111;
        misaligned = (addr[1:0] != 2'b00);
      end
      default: mode_illegal = 1'b1;
    endcase
  end

  // Load result is formed from the lane captured at start, not the live address.
  always_comb begin
    ld_byte = mem_rdata[8*lane_r +: 8];
    ld_half = lane_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (mode_r)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'h0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'h0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mode_r    <= 3'b000;
      lane_r    <= 2'b00;
      fault_r   <= 1'b0;
      cause_r   <= CAUSE_NONE;
      tmo_cnt   <= 16'h0;
      rdata     <= 32'h0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r <= memory_mode;
            lane_r <= addr[1:0];
            if (mode_illegal) begin
              fault_r <= 1'b1;
              cause_r <= CAUSE_ILLEGAL;
              state   <= S_DONE;
            end else if (misaligned) begin
              fault_r <= 1'b1;
              cause_r <= CAUSE_MISALIGN;
              state   <= S_DONE;
            end else begin
              fault_r   <= 1'b0;
              cause_r   <= CAUSE_NONE;
              mem_we    <= store;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_be    <= be_n;
              mem_wdata <= wd_n;
              tmo_cnt   <= 16'h0;
              state     <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            if (!mem_we) rdata <= ld_ext;
            state <= S_DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            fault_r <= 1'b1;
            cause_r <= CAUSE_TIMEOUT;
            state   <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'h1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed test-plan cases, random
// legal accesses, and a result scoreboard drained on every done pulse.
module tb_mem_access_unit;

  localparam int W = 35;  // {fault, fault_cause, rdata}

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, load, store;
  logic [2:0]  memory_mode;
  logic [31:0] addr, wdata;
  logic        stall, done, fault;
  logic [1:0]  fault_cause;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int           n_vec  = 0;
  int           n_err  = 0;
  int           n_ops  = 0;
  int           n_done = 0;
  logic [31:0]  last_rdata;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid(valid), .load(load), .store(store),
    .memory_mode(memory_mode), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .fault(fault), .fault_cause(fault_cause),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model of lane selection and extension.
  function automatic logic [31:0] model_load(input logic [2:0] m, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0:    b = rd[7:0];
      2'd1:    b = rd[15:8];
      2'd2:    b = rd[23:16];
      default: b = rd[31:24];
    endcase
    h = a[1] ? rd[31:16] : rd[15:0];
    case (m)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [2:0] m, input logic [1:0] a);
    case (m[1:0])
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] model_wd(input logic [2:0] m, input logic [31:0] wd);
    case (m[1:0])
      2'b00:   return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
      2'b01:   return {wd[15:0], wd[15:0]};
      default: return wd;
    endcase
  endfunction

  // Scoreboard: every done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      check("done_has_pending_op", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        check("result", {fault, fault_cause, rdata}, exp_q.pop_front());
        check("stall_on_done", stall, 0);
        n_done++;
      end
    end
  end

  // Drives one op and plays the bus; ack_dly = cycles of REQ before ack (large = never).
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] m,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_dly, input logic exp_fault, input logic [1:0] exp_cause,
                        input int exp_lat);
    int   lat;
    int   waited;
    int   req_cycles;
    logic exp_req;
    logic [31:0] exp_rd;
    exp_req = !exp_fault || (exp_cause == 2'b11);
    exp_rd  = (!exp_fault && ld && !st) ? model_load(m, a, rd) : last_rdata;
    @(negedge clk);
    valid = 1'b1; load = ld; store = st; memory_mode = m; addr = a; wdata = wd;
    #1 check({tag, "_stall_start"}, stall, 1);
    exp_q.push_back({exp_fault, exp_cause, exp_rd});
    n_ops++;
    @(posedge clk); #1;
    valid = 1'b0; load = 1'($urandom); store = 1'($urandom);
    memory_mode = 3'($urandom_range(0, 7)); addr = $urandom; wdata = $urandom;
    lat = 1;
    req_cycles = mem_req ? 1 : 0;
    check({tag, "_req"}, mem_req, exp_req);
    if (exp_req) begin
      check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
      check({tag, "_we"}, mem_we, st);
      check({tag, "_be"}, mem_be, model_be(m, a[1:0]));
      if (st) check({tag, "_wdata"}, mem_wdata, model_wd(m, wd));
      check({tag, "_stall_req"}, stall, 1);
      waited = 0;
      while (mem_req && waited < ack_dly && lat < 60) begin
        @(posedge clk); #1;
        lat++; waited++;
        if (mem_req) begin
          req_cycles++;
          check({tag, "_be_stable"}, mem_be, model_be(m, a[1:0]));
        end
      end
      if (mem_req) begin
        mem_ack = 1'b1; mem_rdata = rd;
        @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = $urandom;
        lat++;
      end
      check({tag, "_req_cycles"}, req_cycles, exp_lat - 1);
    end
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_done"}, done, 1);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, done, 0);
    if (!exp_fault && ld && !st) last_rdata = exp_rd;
  endtask

  initial begin
    logic [2:0] legal_modes [5];
    legal_modes = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
    rst = 1'b1; valid = 1'b0; load = 1'b0; store = 1'b0; memory_mode = 3'b000;
    addr = 32'h0; wdata = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    last_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", stall, 0);
    check("rst_done", done, 0);
    check("rst_fault", {fault, fault_cause}, 0);
    check("rst_req", {mem_req, mem_we, mem_be}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bus", {mem_addr, mem_wdata}, 0);
    @(negedge clk) rst = 1'b0;

    run_op("ld_sb",   1, 0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 0, 2'b00, 2);
    check("ld_sb_val", last_rdata, 32'hFFFF_FF80);
    run_op("ld_uh",   1, 0, 3'b101, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 3, 0, 2'b00, 5);
    check("ld_uh_val", last_rdata, 32'h0000_BEEF);
    run_op("st_b",    0, 1, 3'b000, 32'h0000_0010, 32'h1234_56AB, 32'hFFFF_FFFF, 1, 0, 2'b00, 3);
    run_op("st_mis",  0, 1, 3'b011, 32'h0000_0006, 32'h5555_AAAA, 32'h0, 0, 1, 2'b01, 1);
    run_op("ld_ill",  1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, 1, 2'b10, 1);
    run_op("ld_mish", 1, 0, 3'b001, 32'h0000_0201, 32'h0, 32'h0, 0, 1, 2'b01, 1);
    run_op("ld_tmo",  1, 0, 3'b011, 32'h0000_3000, 32'h0, 32'h0, 1000, 1, 2'b11, 5);
    run_op("ld_sh",   1, 0, 3'b001, 32'h0000_4000, 32'h0, 32'h1234_8001, 0, 0, 2'b00, 2);
    run_op("ldst_w",  1, 1, 3'b011, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 2, 0, 2'b00, 4);

    // Idle-time noise: no op offered, stray ack must be ignored.
    @(negedge clk);
    valid = 1'b1; load = 1'b0; store = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_5A5A;
    #1 check("noop_stall", stall, 0);
    @(posedge clk); #1;
    check("noop_req", mem_req, 0);
    check("noop_rdata", rdata, last_rdata);
    mem_ack = 1'b0; valid = 1'b0;

    for (int i = 0; i < 12; i++) begin
      logic [2:0]  m;
      logic [31:0] a;
      logic        st;
      int          dly;
      m   = legal_modes[$urandom_range(0, 4)];
      a   = $urandom;
      if (m[1:0] == 2'b01) a[0] = 1'b0;
      if (m[1:0] == 2'b11) a[1:0] = 2'b00;
      st  = 1'($urandom);
      dly = $urandom_range(0, 3);
      run_op("rnd", !st, st, m, a, $urandom, $urandom, dly, 0, 2'b00, dly + 2);
    end

    // Reset in the middle of a bus request drops it combinationally.
    @(negedge clk);
    valid = 1'b1; load = 1'b1; store = 1'b0; memory_mode = 3'b011; addr = 32'h0000_5000;
    @(posedge clk); #1;
    valid = 1'b0; load = 1'b0;
    check("rreq_req", mem_req, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rreq_req_drop", mem_req, 0);
    check("rreq_stall_drop", stall, 0);
    check("rreq_done", done, 0);
    check("rreq_rdata", rdata, 0);
    last_rdata = 32'h0;
    @(negedge clk) rst = 1'b0;
    run_op("ld_after_rst", 1, 0, 3'b100, 32'h0000_6001, 32'h0, 32'h0000_F700, 1, 0, 2'b00, 3);
    check("ld_after_rst_val", last_rdata, 32'h0000_00F7);

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("done_count", n_done, n_ops);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
